// File: rtl/counter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : counter_pkg
// Description : Shared constants and helpers for the counting primitives.
// Revision    : 1.0 - initial release
// ============================================================================
package counter_pkg;

  // End-of-range behaviour selectors for the SATURATE parameter.
  localparam int CNT_WRAP = 0;
  localparam int CNT_SAT  = 1;

  // Bits needed to hold values 0..v-1 (never less than 1). Parents use this
  // to size WIDTH from the modulus they need.
  function automatic int clog2(input longint unsigned v);
    int n;
    n = 0;
    for (int i = 0; i < 64; i++) begin
      if ((64'd1 << i) < v) begin
        n = i + 1;
      end
    end
    if (n == 0) begin
      n = 1;
    end
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cnt_next_val.sv
`default_nettype none
// ============================================================================
// Module      : cnt_next_val
// Description : Combinational one-step successor/predecessor within 0..MOD-1,
//               with wrap or saturate at the range ends and a wrap flag.
// Revision    : 1.0 - initial release
// ============================================================================
module cnt_next_val
  import counter_pkg::*;
#(
  parameter int     WIDTH    = 4,
  parameter longint MOD      = 16,
  parameter int     SATURATE = CNT_WRAP
) (
  input  logic [WIDTH-1:0] q_i,
  input  logic             up_i,
  output logic [WIDTH-1:0] next_o,
  output logic             wrap_o
);

  // One extra bit keeps the top value and the +1/-1 steps exact even
  // when the modulus equals 2^WIDTH.
  localparam logic [WIDTH:0] TOP_EXT = (WIDTH+1)'(MOD - 1);
  localparam logic [WIDTH:0] ONE_EXT = (WIDTH+1)'(1);

  logic [WIDTH:0] q_ext;
  logic [WIDTH:0] step_ext;
  logic           unused_step_msb;

  // Step one position in the requested direction, folding at the range ends.
  always_comb begin
    q_ext    = {1'b0, q_i};
    step_ext = q_ext;
    wrap_o   = 1'b0;
    if (up_i) begin
      if (q_ext == TOP_EXT) begin
        if (SATURATE != CNT_SAT) begin
          step_ext = '0;
          wrap_o   = 1'b1;
        end
      end else begin
        step_ext = q_ext + ONE_EXT;
      end
    end else begin
      if (q_ext == '0) begin
        if (SATURATE != CNT_SAT) begin
          step_ext = TOP_EXT;
          wrap_o   = 1'b1;
        end
      end else begin
        step_ext = q_ext - ONE_EXT;
      end
    end
  end

  // Results never exceed MOD-1, so the guard bit is always zero here.
  assign next_o          = step_ext[WIDTH-1:0];
  assign unused_step_msb = step_ext[WIDTH];

endmodule
`default_nettype wire

// File: rtl/updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : updown_mod_counter
// Description : Parametrised synchronous up/down modulo counter with enable,
//               clear, clamped load, wrap/saturate mode and a cascadable
//               combinational terminal count.
// Revision    : 1.0 - initial release
// ============================================================================
module updown_mod_counter
  import counter_pkg::*;
#(
  parameter int     WIDTH     = 4,
  parameter longint MOD       = 16,
  parameter int     SATURATE  = CNT_WRAP,
  parameter longint RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up,
  input  logic             clr,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             wrapped,
  output logic             load_err
);

  // Reject illegal parameter sets at elaboration rather than at run time.
  generate
    if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
      $error("updown_mod_counter: WIDTH must be in 1..32");
    end
    if (MOD < 2 || MOD > (longint'(1) << WIDTH)) begin : g_bad_mod
      $error("updown_mod_counter: MOD must be in 2..2^WIDTH");
    end
    if (SATURATE != CNT_WRAP && SATURATE != CNT_SAT) begin : g_bad_sat
      $error("updown_mod_counter: SATURATE must be 0 or 1");
    end
    if (RESET_VAL < 0 || RESET_VAL >= MOD) begin : g_bad_rst
      $error("updown_mod_counter: RESET_VAL must be below MOD");
    end
  endgenerate

  localparam logic [WIDTH-1:0] TOP_V   = WIDTH'(MOD - 1);
  localparam logic [WIDTH-1:0] RST_V   = WIDTH'(RESET_VAL);
  localparam logic [WIDTH:0]   MOD_EXT = (WIDTH+1)'(MOD);

  logic [WIDTH-1:0] cnt_q,  cnt_d;
  logic             wrap_q, wrap_d;
  logic             lerr_q, lerr_d;
  logic [WIDTH-1:0] step_val;
  logic             step_wrap;

  cnt_next_val #(
    .WIDTH    (WIDTH),
    .MOD      (MOD),
    .SATURATE (SATURATE)
  ) u_next (
    .q_i    (cnt_q),
    .up_i   (up),
    .next_o (step_val),
    .wrap_o (step_wrap)
  );

  // Priority mux clr > load > en > hold; the pulse flags default low.
  always_comb begin
    cnt_d  = cnt_q;
    wrap_d = 1'b0;
    lerr_d = 1'b0;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        cnt_d = load_val;
      end else begin
        cnt_d  = TOP_V;
        lerr_d = 1'b1;
      end
    end else if (en) begin
      cnt_d  = step_val;
      wrap_d = step_wrap;
    end
  end

  // State registers; reset overrides every other control.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q  <= RST_V;
      wrap_q <= 1'b0;
      lerr_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
      lerr_q <= lerr_d;
    end
  end

  // Unregistered so a following stage can use it as its enable on this edge.
  assign tc       = en & (up ? (cnt_q == TOP_V) : (cnt_q == '0));
  assign q        = cnt_q;
  assign wrapped  = wrap_q;
  assign load_err = lerr_q;

endmodule
`default_nettype wire

// File: tb/tb_updown_mod_counter.sv
`default_nettype none
// ============================================================================
// Module      : tb_updown_mod_counter
// Description : Self-checking bench for updown_mod_counter over several
//               parameter sets plus a two-digit decimal cascade.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_updown_mod_counter;

  localparam int NI = 5;
  // Instances: default, MOD10 wrap RESET_VAL=3, MOD10 saturate, W1 MOD2, W8 MOD256
  localparam int MODS [NI] = '{16, 10, 10, 2, 256};
  localparam int SATS [NI] = '{0, 0, 1, 0, 0};
  localparam int RVS  [NI] = '{0, 3, 0, 0, 0};
  localparam int WBS  [NI] = '{4, 4, 4, 1, 8};

  logic       clk = 1'b0;
  logic       rst = 1'b0, en = 1'b0, up = 1'b0, clr = 1'b0, load = 1'b0;
  logic [7:0] lv = 8'd0;
  logic       en_c = 1'b0;

  logic [3:0] q_a, q_b, q_c, q_s1, q_s2;
  logic       q_d;
  logic [7:0] q_e;
  logic       tc_a, tc_b, tc_c, tc_d, tc_e, tc_s1, tc_s2;
  logic       w_a, w_b, w_c, w_d, w_e, w_s1, w_s2;
  logic       le_a, le_b, le_c, le_d, le_e, le_s1, le_s2;

  logic [7:0] oq  [NI];
  logic       otc [NI];
  logic       ow  [NI];
  logic       ole [NI];

  int  mq [NI];
  bit  mw [NI];
  bit  ml [NI];
  int  cc = 0;
  bit  mvalid = 1'b0;
  int  errs = 0;
  int  checks = 0;

  always #5 clk = ~clk;

  updown_mod_counter #(.WIDTH(4), .MOD(16), .SATURATE(0), .RESET_VAL(0)) u_a (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[3:0]), .q(q_a), .tc(tc_a), .wrapped(w_a), .load_err(le_a));
  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RESET_VAL(3)) u_b (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[3:0]), .q(q_b), .tc(tc_b), .wrapped(w_b), .load_err(le_b));
  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(1), .RESET_VAL(0)) u_c (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[3:0]), .q(q_c), .tc(tc_c), .wrapped(w_c), .load_err(le_c));
  updown_mod_counter #(.WIDTH(1), .MOD(2), .SATURATE(0), .RESET_VAL(0)) u_d (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv[0]), .q(q_d), .tc(tc_d), .wrapped(w_d), .load_err(le_d));
  updown_mod_counter #(.WIDTH(8), .MOD(256), .SATURATE(0), .RESET_VAL(0)) u_e (
    .clk(clk), .rst(rst), .en(en), .up(up), .clr(clr), .load(load),
    .load_val(lv), .q(q_e), .tc(tc_e), .wrapped(w_e), .load_err(le_e));

  // Decimal pair: units stage enables the tens stage through its tc.
  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RESET_VAL(0)) u_s1 (
    .clk(clk), .rst(rst), .en(en_c), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(q_s1), .tc(tc_s1), .wrapped(w_s1), .load_err(le_s1));
  updown_mod_counter #(.WIDTH(4), .MOD(10), .SATURATE(0), .RESET_VAL(0)) u_s2 (
    .clk(clk), .rst(rst), .en(tc_s1), .up(1'b1), .clr(1'b0), .load(1'b0),
    .load_val(4'd0), .q(q_s2), .tc(tc_s2), .wrapped(w_s2), .load_err(le_s2));

  assign oq[0] = {4'b0, q_a};
  assign oq[1] = {4'b0, q_b};
  assign oq[2] = {4'b0, q_c};
  assign oq[3] = {7'b0, q_d};
  assign oq[4] = q_e;
  assign otc[0] = tc_a; assign otc[1] = tc_b; assign otc[2] = tc_c;
  assign otc[3] = tc_d; assign otc[4] = tc_e;
  assign ow[0] = w_a; assign ow[1] = w_b; assign ow[2] = w_c;
  assign ow[3] = w_d; assign ow[4] = w_e;
  assign ole[0] = le_a; assign ole[1] = le_b; assign ole[2] = le_c;
  assign ole[3] = le_d; assign ole[4] = le_e;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference: what one clock edge does to each counter, from the rules.
  task automatic model_edge();
    for (int k = 0; k < NI; k++) begin
      int lvk;
      lvk   = int'(lv) % (1 << WBS[k]);
      mw[k] = 1'b0;
      ml[k] = 1'b0;
      if (rst) begin
        mq[k] = RVS[k];
      end else if (clr) begin
        mq[k] = 0;
      end else if (load) begin
        if (lvk < MODS[k]) mq[k] = lvk;
        else begin
          mq[k] = MODS[k] - 1;
          ml[k] = 1'b1;
        end
      end else if (en) begin
        int nx;
        nx = up ? mq[k] + 1 : mq[k] - 1;
        if (nx < 0 || nx >= MODS[k]) begin
          if (SATS[k] == 0) begin
            mq[k] = (nx + MODS[k]) % MODS[k];
            mw[k] = 1'b1;
          end
        end else begin
          mq[k] = nx;
        end
      end
    end
    if (rst) cc = 0;
    else if (en_c) cc = (cc + 1) % 100;
    if (rst) mvalid = 1'b1;
  endtask

  // Drive one cycle's controls, check tc before the edge, outputs after it.
  task automatic cycle(input bit r, input bit c, input bit l, input logic [7:0] v,
                       input bit e, input bit u, input bit ec);
    rst = r; clr = c; load = l; lv = v; en = e; up = u; en_c = ec;
    #1;
    if (mvalid) begin
      for (int k = 0; k < NI; k++) begin
        bit t;
        t = e && (u ? (mq[k] == MODS[k] - 1) : (mq[k] == 0));
        chk($sformatf("tc[%0d]", k), 64'(otc[k]), 64'(t));
      end
      chk("tc_s1", 64'(tc_s1), 64'(ec && (cc % 10 == 9)));
    end
    @(posedge clk);
    model_edge();
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      chk($sformatf("q[%0d]", k), 64'(oq[k]), 64'(mq[k]));
      chk($sformatf("wrapped[%0d]", k), 64'(ow[k]), 64'(mw[k]));
      chk($sformatf("load_err[%0d]", k), 64'(ole[k]), 64'(ml[k]));
    end
    chk("cas_units", 64'(q_s1), 64'(cc % 10));
    chk("cas_tens", 64'(q_s2), 64'(cc / 10));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) cycle(1, 0, 0, 8'd0, 0, 0, 0);       // reset
    repeat (17) cycle(0, 0, 0, 8'd0, 1, 1, 1);      // count up through wrap
    cycle(0, 1, 0, 8'd0, 0, 0, 1);                  // clear
    repeat (3) cycle(0, 0, 0, 8'd0, 1, 0, 1);       // down from 0
    cycle(0, 0, 1, 8'd7, 0, 0, 1);                  // in-range load
    cycle(0, 0, 1, 8'd12, 0, 0, 1);                 // out-of-range load
    repeat (2) cycle(0, 0, 0, 8'd0, 0, 1, 1);       // hold
    cycle(0, 0, 1, 8'd5, 1, 1, 1);                  // load beats enable
    cycle(0, 1, 1, 8'd12, 1, 1, 1);                 // clear beats load
    repeat (4) cycle(0, 0, 0, 8'd0, 1, 1, 1);
    cycle(1, 0, 1, 8'd12, 1, 1, 1);                 // reset mid-count
    repeat (300) cycle(0, 0, 0, 8'd0, 1, 1, 1);     // cascade 00..99, full 8-bit wrap
    for (int i = 0; i < 1500; i++) begin
      cycle(($urandom % 64) == 0, ($urandom % 16) == 0, ($urandom % 8) == 0,
            8'($urandom), ($urandom % 4) != 0, 1'($urandom), ($urandom % 8) != 0);
    end
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
`default_nettype wire
